// File: rtl/cache_fill_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm_pkg
// Purpose  : Shared constants, controller state type and block-address helper
//            for the cache miss fill controller.
// Contents : CACHE_* geometry constants, fill_state_e, block_base().
// Revision : 1.0 - initial release
// ============================================================================
package cache_fill_fsm_pkg;

  localparam int CACHE_ADDR_WIDTH    = 16;
  localparam int CACHE_DATA_WIDTH    = 16;
  localparam int CACHE_BLOCK_WORDS   = 8;
  localparam int CACHE_OFFSET_BITS   = 4;
  localparam int CACHE_WORD_IDX_BITS = $clog2(CACHE_BLOCK_WORDS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Clears the byte-offset bits so the result points at word 0 of the block.
  // Kept 32 bits wide so any address width up to 32 can use it.
  function automatic logic [31:0] block_base(input logic [31:0] addr,
                                             input int unsigned off_bits);
    logic [31:0] mask;
    mask = ~((32'd1 << off_bits) - 32'd1);
    return addr & mask;
  endfunction

endpackage : cache_fill_fsm_pkg
`default_nettype wire

// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm_if
// Purpose  : Bundle of the cache-side miss signals, memory request/response
//            bus and cache array write port used by the fill controller.
// Modports : master - the fill controller (drives requests and array writes)
//            slave  - cache pipeline plus main memory (drives miss and data)
// Revision : 1.0 - initial release
// ============================================================================
interface cache_fill_fsm_if #(
  parameter int ADDR_WIDTH    = 16,
  parameter int WORD_IDX_BITS = 3,
  parameter int DATA_WIDTH    = 16
);

  logic                     miss_detected;
  logic [ADDR_WIDTH-1:0]    miss_address;
  logic                     fsm_busy;
  logic                     mem_enable;
  logic                     mem_wr;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]    memory_data;
  logic                     memory_data_valid;
  logic                     write_data_array;
  logic [WORD_IDX_BITS-1:0] word_index;
  logic [DATA_WIDTH-1:0]    fill_data;
  logic                     write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output fsm_busy, mem_enable, mem_wr, mem_addr,
           write_data_array, word_index, fill_data, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  fsm_busy, mem_enable, mem_wr, mem_addr,
           write_data_array, word_index, fill_data, write_tag_array
  );

endinterface : cache_fill_fsm_if
`default_nettype wire

// File: rtl/cache_fill_fsm_counter.sv
`default_nettype none
// ============================================================================
// Module   : cache_word_counter
// Purpose  : Saturating word counter for one side (request or response) of a
//            block fill. Counts 0..LIMIT and then holds.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            clear_i       - restart the count at zero (new fill)
//            inc_i         - advance by one word
//            count_o       - current count
//            done_o        - count has reached LIMIT
// Revision : 1.0 - initial release
// ============================================================================
module cache_word_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;
  logic             w_done;

  assign w_done = (count_q == WIDTH'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (inc_i && !w_done) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign done_o  = w_done;

endmodule : cache_word_counter
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm
// Purpose  : Cache miss fill controller. On a miss it streams one memory read
//            per cycle for every word of the block, writes each returned word
//            into the data array as it arrives, and writes the tag array with
//            the last word before returning to idle.
// Ports    : clk      - system clock
//            rst      - synchronous active-high reset
//            fill_bus - cache_fill_fsm_if.master (miss in, memory bus, array
//                       write port out)
// Options  : CACHE_CRITICAL_WORD_FIRST_EN - when defined, the fill starts at
//            the missing word and wraps around the block; otherwise word 0
//            is fetched first.
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH  = CACHE_ADDR_WIDTH,
  parameter int BLOCK_WORDS = CACHE_BLOCK_WORDS,
  parameter int OFFSET_BITS = CACHE_OFFSET_BITS
) (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master fill_bus
);

  localparam int WORD_IDX_BITS = OFFSET_BITS - 1;

  fill_state_e              state_q;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [WORD_IDX_BITS-1:0] start_q;

  logic [OFFSET_BITS-1:0]   w_req_cnt;
  logic [OFFSET_BITS-1:0]   w_rsp_cnt;
  logic                     w_req_done;
  logic                     w_rsp_done;
  logic                     w_fill;
  logic                     w_accept;
  logic                     w_req_en;
  logic                     w_rsp_en;
  logic                     w_last_rsp;
  logic [ADDR_WIDTH-1:0]    w_miss_base;
  logic [WORD_IDX_BITS-1:0] w_miss_start;
  logic [WORD_IDX_BITS-1:0] w_req_word;
  logic [WORD_IDX_BITS-1:0] w_rsp_word;

  assign w_miss_base = ADDR_WIDTH'(block_base(32'(fill_bus.miss_address),
                                              OFFSET_BITS));

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign w_miss_start = fill_bus.miss_address[OFFSET_BITS-1:1];
`else
  assign w_miss_start = '0;
`endif

  // Outputs are forced quiet while reset is held, even before the state
  // register has been cleared.
  assign w_fill     = (state_q == FILL) && !rst;
  assign w_accept   = (state_q == IDLE) && fill_bus.miss_detected;
  assign w_req_en   = w_fill && !w_req_done;
  // A valid beyond the last expected word cannot be produced by the memory;
  // masking it with w_rsp_done keeps the counter and array safe regardless.
  assign w_rsp_en   = w_fill && fill_bus.memory_data_valid && !w_rsp_done;
  assign w_last_rsp = w_rsp_en && (w_rsp_cnt == OFFSET_BITS'(BLOCK_WORDS - 1));

  // Word position inside the block wraps naturally at WORD_IDX_BITS, giving
  // the modulo-BLOCK_WORDS rotation for critical-word-first ordering.
  assign w_req_word = start_q + w_req_cnt[WORD_IDX_BITS-1:0];
  assign w_rsp_word = start_q + w_rsp_cnt[WORD_IDX_BITS-1:0];

  cache_word_counter #(
    .WIDTH (OFFSET_BITS),
    .LIMIT (BLOCK_WORDS)
  ) u_req_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (w_accept),
    .inc_i   (w_req_en),
    .count_o (w_req_cnt),
    .done_o  (w_req_done)
  );

  cache_word_counter #(
    .WIDTH (OFFSET_BITS),
    .LIMIT (BLOCK_WORDS)
  ) u_rsp_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (w_accept),
    .inc_i   (w_rsp_en),
    .count_o (w_rsp_cnt),
    .done_o  (w_rsp_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      start_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fill_bus.miss_detected) begin
            base_q  <= w_miss_base;
            start_q <= w_miss_start;
            state_q <= FILL;
          end
        end
        FILL: begin
          // Misses seen here are dropped; the cache re-presents them once
          // the stall is released.
          if (w_last_rsp) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fill_bus.fsm_busy         = w_fill;
  assign fill_bus.mem_enable       = w_req_en;
  assign fill_bus.mem_wr           = 1'b0;
  assign fill_bus.mem_addr         = w_req_en ?
                                     base_q + ADDR_WIDTH'({w_req_word, 1'b0}) :
                                     '0;
  assign fill_bus.write_data_array = w_rsp_en;
  assign fill_bus.word_index       = w_rsp_en ? w_rsp_word : '0;
  assign fill_bus.fill_data        = fill_bus.memory_data;
  assign fill_bus.write_tag_array  = w_last_rsp;

endmodule : cache_fill_fsm
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_fsm
// Purpose  : Self-checking bench for cache_fill_fsm. A transaction-level
//            memory model answers requests; a scoreboard predicts the request
//            stream and array writes of each fill from the miss address.
//            Directed cycle tables cover the exact fill timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_fsm_if #(.ADDR_WIDTH(16), .WORD_IDX_BITS(3), .DATA_WIDTH(16)) bus ();

  cache_fill_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .fill_bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int start_of(input logic [15:0] a);
    return CWF ? int'(a[3:1]) : 0;
  endfunction

  // ---------------- memory model: mem[i] = i, latency >= 4 ----------------
  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;
  req_t pend[$];
  int   last_due  = 0;
  int   m_due     = 0;
  int   m_lo      = 0;
  bit   irregular = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_enable === 1'b1) begin
      m_due = cyc + 4;
      m_lo  = last_due + 1 + (irregular ? int'($urandom_range(0, 3)) : 0);
      if (m_lo > m_due) m_due = m_lo;
      last_due = m_due;
      pend.push_back('{addr: bus.mem_addr, due: m_due});
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = pend[0].addr >> 1;
      pend.pop_front();
    end else begin
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'h0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [2:0]  idx;
    logic [15:0] data;
  } wr_t;
  logic [15:0] exp_req[$];
  wr_t         exp_wr[$];
  bit          m_busy     = 1'b0;
  int          tags_seen  = 0;
  int          fills_done = 0;

  task automatic plan_fill(input logic [15:0] a);
    logic [15:0] base;
    logic [15:0] wa;
    int          s;
    int          w;
    base = a & 16'hFFF0;
    s    = start_of(a);
    for (int i = 0; i < 8; i++) begin
      w  = (s + i) % 8;
      wa = base + 16'(2 * w);
      exp_req.push_back(wa);
      exp_wr.push_back('{idx: 3'(w), data: wa >> 1});
    end
  endtask

  always @(negedge clk) begin
    chk("mem_wr", 32'(bus.mem_wr), 0);
    if (bus.write_tag_array === 1'b1) tags_seen++;
    if (rst) begin
      chk("rst_busy", 32'(bus.fsm_busy), 0);
      chk("rst_en",   32'(bus.mem_enable), 0);
      chk("rst_addr", 32'(bus.mem_addr), 0);
      chk("rst_wr",   32'(bus.write_data_array), 0);
      chk("rst_idx",  32'(bus.word_index), 0);
      chk("rst_tag",  32'(bus.write_tag_array), 0);
      m_busy = 1'b0;
      exp_req.delete();
      exp_wr.delete();
    end else if (!m_busy) begin
      chk("idle_busy", 32'(bus.fsm_busy), 0);
      chk("idle_en",   32'(bus.mem_enable), 0);
      chk("idle_addr", 32'(bus.mem_addr), 0);
      chk("idle_wr",   32'(bus.write_data_array), 0);
      chk("idle_idx",  32'(bus.word_index), 0);
      chk("idle_tag",  32'(bus.write_tag_array), 0);
      if (bus.miss_detected === 1'b1) begin
        m_busy = 1'b1;
        plan_fill(bus.miss_address);
      end
    end else begin
      chk("fill_busy", 32'(bus.fsm_busy), 1);
      if (exp_req.size() > 0) begin
        chk("req_en",   32'(bus.mem_enable), 1);
        chk("req_addr", 32'(bus.mem_addr), 32'(exp_req[0]));
        void'(exp_req.pop_front());
      end else begin
        chk("req_en_off",   32'(bus.mem_enable), 0);
        chk("req_addr_off", 32'(bus.mem_addr), 0);
      end
      if (bus.memory_data_valid === 1'b1 && exp_wr.size() > 0) begin
        chk("wr",        32'(bus.write_data_array), 1);
        chk("wr_idx",    32'(bus.word_index), 32'(exp_wr[0].idx));
        chk("fill_data", 32'(bus.fill_data), 32'(exp_wr[0].data));
        chk("tag",       32'(bus.write_tag_array), (exp_wr.size() == 1) ? 1 : 0);
        void'(exp_wr.pop_front());
        if (exp_wr.size() == 0) begin
          m_busy = 1'b0;
          fills_done++;
        end
      end else begin
        chk("wr_off",  32'(bus.write_data_array), 0);
        chk("idx_off", 32'(bus.word_index), 0);
        chk("tag_off", 32'(bus.write_tag_array), 0);
      end
    end
  end

  // ---------------- directed cycle tables ----------------
  typedef struct {
    logic        miss;
    logic        busy;
    logic        en;
    logic [15:0] addr;
    logic        wr;
    logic [2:0]  idx;
    logic [15:0] data;
    logic        tag;
  } vec_t;
  vec_t tbl[15];

  task automatic build_tbl(input logic [15:0] a);
    logic [15:0] base;
    int          s;
    base = a & 16'hFFF0;
    s    = start_of(a);
    for (int c = 0; c < 15; c++) begin
      tbl[c].miss = (c == 0);
      tbl[c].busy = (c >= 1 && c <= 12);
      tbl[c].en   = (c >= 1 && c <= 8);
      tbl[c].addr = tbl[c].en ? base + 16'(2 * ((s + c - 1) % 8)) : 16'h0;
      tbl[c].wr   = (c >= 5 && c <= 12);
      tbl[c].idx  = tbl[c].wr ? 3'((s + c - 5) % 8) : 3'd0;
      tbl[c].data = tbl[c].wr ? (base >> 1) + 16'((s + c - 5) % 8) : 16'h0;
      tbl[c].tag  = (c == 12);
    end
  endtask

  // Call aligned just after a rising edge, with the controller idle.
  task automatic run_tbl(input logic [15:0] a);
    build_tbl(a);
    bus.miss_address = a;
    for (int c = 0; c < 15; c++) begin
      bus.miss_detected = tbl[c].miss;
      @(negedge clk);
      chk("t_busy", 32'(bus.fsm_busy), 32'(tbl[c].busy));
      chk("t_en",   32'(bus.mem_enable), 32'(tbl[c].en));
      chk("t_addr", 32'(bus.mem_addr), 32'(tbl[c].addr));
      chk("t_wr",   32'(bus.write_data_array), 32'(tbl[c].wr));
      chk("t_idx",  32'(bus.word_index), 32'(tbl[c].idx));
      chk("t_tag",  32'(bus.write_tag_array), 32'(tbl[c].tag));
      if (tbl[c].wr) chk("t_data", 32'(bus.fill_data), 32'(tbl[c].data));
      @(posedge clk); #1;
    end
    bus.miss_detected = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy || pend.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n < 300) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.miss_detected     = 1'b1;
    bus.miss_address      = 16'h3456;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'h0;

    // Reset held with a miss pending: all quiet, then the miss starts a fill.
    repeat (3) begin
      @(negedge clk);
      chk("r_busy", 32'(bus.fsm_busy), 0);
      chk("r_en",   32'(bus.mem_enable), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.miss_detected = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.fsm_busy), 1);
    chk("post_rst_addr", 32'(bus.mem_addr), 32'(16'h3450 + 16'(2 * start_of(16'h3456))));
    wait_idle();

    // Exact fill timing, linear and (when enabled) critical-word-first.
    run_tbl(16'h1236);
    wait_idle();
    run_tbl(16'h123A);
    wait_idle();

    // Back-to-back misses: second held from cycle 10, accepted in cycle 13.
    for (int c = 0; c < 15; c++) begin
      bus.miss_detected = (c == 0) || (c >= 10 && c <= 13);
      bus.miss_address  = (c == 0) ? 16'h0040 : 16'h0080;
      @(negedge clk);
      if (c == 12) chk("b2b_tag12",  32'(bus.write_tag_array), 1);
      if (c == 13) chk("b2b_idle13", 32'(bus.fsm_busy), 0);
      if (c == 14) begin
        chk("b2b_en14",   32'(bus.mem_enable), 1);
        chk("b2b_addr14", 32'(bus.mem_addr), 32'h0080);
      end
      @(posedge clk); #1;
    end
    bus.miss_detected = 1'b0;
    wait_idle();

    // Reset in cycle 6 of a fill: aborted, stray valids ignored.
    for (int c = 0; c < 14; c++) begin
      bus.miss_detected = (c == 0) || (c == 13);
      bus.miss_address  = (c == 0) ? 16'h4446 : 16'h2000;
      rst               = (c == 6);
      @(negedge clk);
      if (c >= 6 && c <= 12) begin
        chk("abort_wr",  32'(bus.write_data_array), 0);
        chk("abort_tag", 32'(bus.write_tag_array), 0);
        chk("abort_busy", 32'(bus.fsm_busy), 0);
      end
      @(posedge clk); #1;
    end
    bus.miss_detected = 1'b0;
    @(negedge clk);
    chk("clean_fill_start", 32'(bus.mem_addr), 32'h2000);
    wait_idle();

    // Random misses with irregular response spacing.
    irregular = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bus.miss_detected = ($urandom_range(0, 3) == 0);
      bus.miss_address  = 16'($urandom);
      @(posedge clk); #1;
    end
    bus.miss_detected = 1'b0;
    wait_idle();
    chk("tag_count", 32'(tags_seen), 32'(fills_done));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cache_fill_fsm
`default_nettype wire

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the cache arrays and the multi-cycle main memory (16-bit words, single-cycle write, 4-cycle pipelined read with data_valid).
- On a cache miss it issues one memory read per cycle for every word of the 16-byte block.
- It writes each returned word into the cache data array as its data_valid arrives.
- It writes the tag array with the last word, then returns to idle.

Parameters:
- ADDR_WIDTH, 16, byte-address width.
- BLOCK_WORDS, 8, 16-bit words per cache block; must be a power of two.
- OFFSET_BITS, 4, byte-offset bits, equal to log2(BLOCK_WORDS*2).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache lookup missed this cycle.
- miss_address  in  ADDR_WIDTH  byte address of the missing access.
- fsm_busy  out  1  fill in progress; pipeline stalls.
- mem_enable  out  1  memory request strobe.
- mem_wr  out  1  memory write strobe; tied 0 (reads only).
- mem_addr  out  ADDR_WIDTH  memory request byte address; bit 0 always 0.
- memory_data  in  16  memory read data.
- memory_data_valid  in  1  memory read data valid.
- write_data_array  out  1  cache data-array word write enable.
- word_index  out  log2(BLOCK_WORDS)  word slot within the block being written.
- fill_data  out  16  data to write; equals memory_data.
- write_tag_array  out  1  cache tag/valid write enable; marks fill complete.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset: state IDLE; base, req_cnt and rsp_cnt cleared. All outputs are 0 during and after reset.
- A reset mid-fill aborts the fill with no tag write. Valid pulses arriving after reset while IDLE are ignored.
- States: IDLE, FILL.
- IDLE:
  - If miss_detected=1, register base = {miss_address[ADDR_WIDTH-1:OFFSET_BITS], 0}, clear both counters, and go to FILL.
  - Otherwise stay in IDLE.
  - memory_data_valid is ignored.
- FILL request side:
  - mem_enable = (req_cnt < BLOCK_WORDS).
  - mem_addr = base + 2*req_cnt while enabled, else 0.
  - req_cnt increments on each enabled cycle, so there is exactly one request per cycle and no gaps.
- FILL response side:
  - On each memory_data_valid: write_data_array=1, word_index=rsp_cnt[2:0], and rsp_cnt increments.
  - The controller counts valids and does not assume a fixed latency.
- Completion: on the valid where rsp_cnt = BLOCK_WORDS-1, assert write_tag_array=1 in the same cycle and go to IDLE next cycle.
- fsm_busy = (state==FILL).
- Other outputs:
  - All other outputs are decoded combinationally from registered state and counters; fill_data is combinational from memory_data.
  - write_data_array, write_tag_array and word_index are 0 when not asserted.
- Timing with 4-cycle memory, miss seen in cycle 0:
  - Requests in cycles 1..8.
  - Data writes in cycles 5..12; tag write in cycle 12.
  - fsm_busy high in cycles 1..12.
  - A new miss is accepted in cycle 13 at the earliest.
- miss_detected during FILL is ignored; the cache re-presents the miss after stall release.
- Counters are OFFSET_BITS wide (0..BLOCK_WORDS), with no wrap.
- memory_data_valid seen when rsp_cnt == BLOCK_WORDS cannot occur; it is ignored.

Optional Feature:
- Macro: CACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - start = miss_address[OFFSET_BITS-1:1] is registered with base.
  - Request i address = base + 2*((start+i) mod BLOCK_WORDS).
  - Response k word_index = (start+k) mod BLOCK_WORDS.
  - The requested word is therefore written first, in cycle 5.
- Undefined: start is fixed at 0, giving the linear order above.
- Both builds: identical cycle counts and tag timing.

Decomposition:
- cache_pkg:
  - state enum (IDLE, FILL).
  - BLOCK_WORDS, OFFSET_BITS and WORD_IDX_BITS constants.
  - Helper function for the block-aligned base address.
- Sub-module cache_word_counter:
  - Ports: clear, increment enable, count, done-at-BLOCK_WORDS flag.
  - Instantiated twice: request counter and response counter.

Test Plan:
- Reset while miss_detected=1 -> all outputs 0, state IDLE; first cycle after reset with miss high starts a fill.
- Miss at 0x1236, 4-cycle memory preloaded mem[i]=i:
  - mem_addr = 0x1230, 0x1232 .. 0x123E in cycles 1..8.
  - word_index 0..7 with fill_data 0x0918..0x091F in cycles 5..12.
  - write_tag_array only in cycle 12; fsm_busy low in cycle 13.
- Back-to-back misses 0x0040 then 0x0080 (second asserted from cycle 10) -> second ignored until cycle 13; accepted there, requests start at 0x0080 in cycle 14.
- Reset asserted in cycle 6 of a fill -> no write_tag_array, outputs 0 from cycle 7, stray valids ignored. Next miss 0x2000 -> full clean fill.
- With CACHE_CRITICAL_WORD_FIRST_EN, miss at 0x123A -> requests 0x123A, 0x123C, 0x123E, 0x1230 .. 0x1238; word_index order 5,6,7,0..4; tag write still in cycle 12.
- Irregular data_valid (memory model with random 0-3 stall cycles between valids) -> exactly 8 data writes, indices in order, one tag write on the 8th valid.
